// File: rtl/uart_rx_fifo_param.sv
// UART receiver with runtime baud divisor, optional parity, 1/2 stop bits
// and a show-ahead RX FIFO carrying per-byte parity/framing error flags.
module uart_rx_fifo_param #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OS         = 16,
  parameter int unsigned DVSR_W     = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              serial_in,
  input  logic              rd_en,
  output logic [DBIT-1:0]   rd_data,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int unsigned SW = $clog2(OS);
  localparam int unsigned NW = $clog2(DBIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DBIT + 2;

  localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic              sync1, rx;
  logic [DVSR_W-1:0] tcnt, div, lim;
  logic              tick;

  state_t            state;
  logic [SW-1:0]     s;
  logic [NW-1:0]     n;
  logic [DBIT-1:0]   sh;
  logic              par_en, par_odd, two_stop, second, perr, ferr;
  logic              push;
  logic [EW-1:0]     push_word;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              do_push, do_pop;

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx    <= sync1;
    end
  end

  // Oversample tick; divisor re-sampled on every tick, 0 treated as 1
  assign lim  = (div == '0) ? '0 : div - DVSR_W'(1);
  assign tick = (tcnt >= lim);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tcnt <= '0;
      div  <= '0;
    end else if (tick) begin
      tcnt <= '0;
      div  <= dvsr;
    end else begin
      tcnt <= tcnt + DVSR_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      sh        <= '0;
      par_en    <= 1'b0;
      par_odd   <= 1'b0;
      two_stop  <= 1'b0;
      second    <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
    end else begin
      push <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_HALF) begin
              if (rx) begin
                state <= IDLE;
              end else begin
                // Frame format is frozen here for the rest of the frame
                state    <= DATA;
                s        <= '0;
                n        <= '0;
                par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_odd  <= (parity_mode == 2'b10);
                two_stop <= stop2;
                second   <= 1'b0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_FULL) begin
              s  <= '0;
              sh <= {rx, sh[DBIT-1:1]};
              n  <= n + NW'(1);
              if (n == N_LAST) state <= par_en ? PARITY : STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s == S_FULL) begin
              s     <= '0;
              perr  <= ((^sh) ^ rx) != par_odd;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == S_FULL) begin
              s <= '0;
              if (two_stop && !second) begin
                second <= 1'b1;
                ferr   <= ferr | ~rx;
              end else begin
                push      <= 1'b1;
                push_word <= {ferr | ~rx, perr, sh};
                state     <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Show-ahead FIFO; extra pointer bit separates full from empty
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = push && (!full || do_pop);
  assign {rd_ferr, rd_perr, rd_data} = mem[rptr[AW-1:0]];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_word;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (do_pop) rptr <= rptr + (AW+1)'(1);
      if (push && full && !do_pop) overrun <= 1'b1;
      else if (clr_ovr)            overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Scoreboard bench for uart_rx_fifo_param: frames are built bit by bit on the
// line, expected FIFO entries are queued at send time and popped by a monitor.
module tb_uart_rx_fifo_param;

  localparam int unsigned DBIT   = 8;
  localparam int unsigned OS     = 16;
  localparam int unsigned DVSR_W = 11;
  localparam int unsigned DEPTH  = 4;

  logic              CLOCK;
  logic              RESET;
  logic [DVSR_W-1:0] dvsr;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic              serial_in;
  logic              rd_en, rd_en_mon, rd_en_man;
  logic [DBIT-1:0]   rd_data;
  logic              rd_perr, rd_ferr, empty, full, overrun;
  logic              clr_ovr;

  logic [DBIT+1:0]   mq[$];
  logic              exp_ovr;
  logic              mon_en;
  int                checks;
  int                passes;

  assign rd_en = rd_en_mon | rd_en_man;

  uart_rx_fifo_param #(
    .DBIT(DBIT), .OS(OS), .DVSR_W(DVSR_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .dvsr(dvsr), .parity_mode(parity_mode),
    .stop2(stop2), .serial_in(serial_in), .rd_en(rd_en), .rd_data(rd_data),
    .rd_perr(rd_perr), .rd_ferr(rd_ferr), .empty(empty), .full(full),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic int bit_clocks();
    return ((dvsr == '0) ? 1 : int'(dvsr)) * int'(OS);
  endfunction

  task automatic idle_bits(input int k);
    serial_in = 1'b1;
    repeat (k * bit_clocks()) @(negedge CLOCK);
  endtask

  // Reference: expected entry from the bits put on the line
  task automatic send_frame(input logic [DBIT-1:0] d, input logic [1:0] pm, input logic s2,
                            input logic bad_par, input logic [1:0] sb, input logic scramble);
    int   bt;
    logic has_par, pb, e_perr, e_ferr;
    bt      = bit_clocks();
    has_par = (pm == 2'b01) || (pm == 2'b10);
    pb      = (^d) ^ (pm == 2'b10) ^ bad_par;
    e_perr  = has_par && (((^d) ^ pb) != (pm == 2'b10));
    e_ferr  = !sb[0] || (s2 && !sb[1]);
    if (mon_en || mq.size() < int'(DEPTH)) mq.push_back({e_ferr, e_perr, d});
    else exp_ovr = 1'b1;
    parity_mode = pm;
    stop2       = s2;
    @(negedge CLOCK);
    serial_in = 1'b0;
    repeat (bt) @(negedge CLOCK);
    for (int i = 0; i < int'(DBIT); i++) begin
      serial_in = d[i];
      if (i == 0 && scramble) begin
        repeat (bt / 2) @(negedge CLOCK);
        parity_mode = 2'($urandom);
        stop2       = 1'($urandom);
        repeat (bt - bt / 2) @(negedge CLOCK);
      end else begin
        repeat (bt) @(negedge CLOCK);
      end
    end
    if (has_par) begin
      serial_in = pb;
      repeat (bt) @(negedge CLOCK);
    end
    for (int k = 0; k <= int'(s2); k++) begin
      serial_in = sb[k];
      if (k == int'(s2) && !sb[k]) begin
        // Release a bad final stop early and idle one bit so no false start follows
        repeat (bt * 3 / 4) @(negedge CLOCK);
        serial_in = 1'b1;
        repeat (bt - bt * 3 / 4 + bt) @(negedge CLOCK);
      end else begin
        repeat (bt) @(negedge CLOCK);
      end
    end
    serial_in = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((mq.size() != 0 || !empty) && k < 20000) begin
      @(negedge CLOCK);
      k++;
    end
    repeat (2) @(negedge CLOCK);
    check({name, "_empty"}, 32'(empty), 32'(1));
    check({name, "_pending"}, 32'(mq.size()), 32'(0));
  endtask

  // Monitor: pop and compare whenever the FIFO presents a head entry
  initial begin
    logic [DBIT+1:0] exp;
    rd_en_mon = 1'b0;
    forever begin
      @(negedge CLOCK);
      rd_en_mon = 1'b0;
      if (mon_en && !RESET && !empty) begin
        if (mq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_entry: got 0x%0h required none", {rd_ferr, rd_perr, rd_data});
        end else begin
          exp = mq.pop_front();
          check("rx_entry", 32'({rd_ferr, rd_perr, rd_data}), 32'(exp));
        end
        rd_en_mon = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [DBIT+1:0] head;
    checks      = 0;
    passes      = 0;
    mon_en      = 1'b0;
    exp_ovr     = 1'b0;
    RESET       = 1'b1;
    dvsr        = DVSR_W'(26);
    parity_mode = 2'b00;
    stop2       = 1'b0;
    serial_in   = 1'b1;
    rd_en_man   = 1'b0;
    clr_ovr     = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_head", 32'({rd_ferr, rd_perr, rd_data}), 32'(0));
    RESET = 1'b0;
    idle_bits(2);

    // 8N1 back-to-back, no reads until all three landed
    send_frame(8'h05, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    send_frame(8'h0A, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    send_frame(8'h0C, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    repeat (4) @(negedge CLOCK);
    check("t1_not_empty", 32'(empty), 32'(0));
    check("t1_not_full", 32'(full), 32'(0));
    mon_en = 1'b1;
    wait_drain("t1");

    // Even parity: good then bad parity bit
    dvsr = DVSR_W'(4);
    idle_bits(2);
    send_frame(8'h05, 2'b01, 1'b0, 1'b0, 2'b11, 1'b0);
    send_frame(8'h05, 2'b01, 1'b0, 1'b1, 2'b11, 1'b0);
    // Framing error followed by a clean frame
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    wait_drain("t23");

    // Short low glitch on idle line must not produce a byte
    dvsr = DVSR_W'(3);
    idle_bits(2);
    mon_en = 1'b0;
    @(negedge CLOCK);
    serial_in = 1'b0;
    repeat (4 * 3) @(negedge CLOCK);
    serial_in = 1'b1;
    idle_bits(12);
    check("t4_glitch_empty", 32'(empty), 32'(mq.size() == 0));
    mon_en = 1'b1;
    send_frame(8'h96, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    wait_drain("t4");

    // Overflow: fifth frame dropped, overrun sticky until cleared
    dvsr = DVSR_W'(1);
    idle_bits(4);
    mon_en = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    repeat (4) @(negedge CLOCK);
    check("t5_full", 32'(full), 32'(mq.size() == int'(DEPTH)));
    check("t5_overrun", 32'(overrun), 32'(exp_ovr));
    clr_ovr = 1'b1;
    @(negedge CLOCK);
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge CLOCK);
    check("t5_clr_ovr", 32'(overrun), 32'(exp_ovr));
    mon_en = 1'b1;
    wait_drain("t5a");

    // Pop on the exact push cycle while full: both happen, no overrun
    mon_en = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    head = mq.pop_front();
    fork
      send_frame(8'h05, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
      begin
        @(negedge CLOCK);
        repeat (3 + OS / 2 + OS * (DBIT + 1)) @(negedge CLOCK);
        check("t5b_head", 32'({rd_ferr, rd_perr, rd_data}), 32'(head));
        rd_en_man = 1'b1;
        @(negedge CLOCK);
        rd_en_man = 1'b0;
      end
    join
    repeat (4) @(negedge CLOCK);
    check("t5b_full", 32'(full), 32'(mq.size() == int'(DEPTH)));
    check("t5b_overrun", 32'(overrun), 32'(exp_ovr));
    mon_en = 1'b1;
    wait_drain("t5b");

    // Reset mid-frame discards FIFO, overrun and the partial byte
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(8'(8'h11 + i), 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    repeat (4) @(negedge CLOCK);
    check("t6_pre_overrun", 32'(overrun), 32'(exp_ovr));
    @(negedge CLOCK);
    serial_in = 1'b0;
    repeat (bit_clocks() * 4) @(negedge CLOCK);
    RESET     = 1'b1;
    serial_in = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    mq.delete();
    exp_ovr = 1'b0;
    check("t6_empty", 32'(empty), 32'(1));
    check("t6_overrun", 32'(overrun), 32'(exp_ovr));
    check("t6_full", 32'(full), 32'(0));
    check("t6_head", 32'({rd_ferr, rd_perr, rd_data}), 32'(0));
    idle_bits(2);
    mon_en = 1'b1;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    wait_drain("t6");

    // Random frames: formats, divisors (incl. 0), errors, mid-frame mode changes
    for (int t = 0; t < 14; t++) begin
      logic [1:0] sb;
      dvsr = DVSR_W'($urandom_range(0, 5));
      idle_bits(2);
      sb = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(8'($urandom), 2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 sb, 1'($urandom));
    end
    wait_drain("rand");
    check("final_overrun", 32'(overrun), 32'(exp_ovr));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
